// File: rtl/ram_fill_pkg.sv
// Shared types, mode encodings and the fill-word generator for ram_fill_writer.
// The generator works at GEN_W bits, and callers resize the result to their own widths.
package ram_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_ONES   = 2'd1;
  localparam logic [1:0] MODE_ADDR   = 2'd2;

  localparam int GEN_W = 256;

  // Reserved mode 3 falls through to all-ones along with MODE_ONES.
  function automatic logic [GEN_W-1:0] gen_word(input logic [1:0] mode,
                                                input logic [GEN_W-1:0] addr);
    if (mode == MODE_ADDR) return addr;
    return '1;
  endfunction

endpackage

// File: rtl/ram_fill_writer_if.sv
// Stream-in / RAM-write-out bundle of ram_fill_writer.
// The master modport is the writer side; the slave modport is the upstream source and the RAM side.
interface ram_fill_writer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (input s_valid, s_data, output s_ready, wr_en, wr_addr, wr_data);
  modport slave  (output s_valid, s_data, input s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ram_fill_pattern_gen.sv
// Combinational fill-word generator.
// One instance feeds the write path; a second instance feeds the verify expected-data path.
module ram_fill_pattern_gen
  import ram_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] word
);
  // The address is zero-extended in, and the result is truncated to DATA_WIDTH on the way out.
  assign word = DATA_WIDTH'(gen_word(mode, GEN_W'(addr)));
endmodule

// File: rtl/ram_fill_writer.sv
// Write-side sequencer that fills RAM addresses 0..2**ADDR_WIDTH-1 from a stream or a generated pattern.
// The optional read-back check is enabled by RAM_FILL_WRITER_VERIFY_EN.
module ram_fill_writer
  import ram_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  ram_fill_writer_if.master     bus,
  output logic                  busy,
  output logic                  done
`ifdef RAM_FILL_WRITER_VERIFY_EN
  ,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            err_cnt,
  output logic                  pass
`endif
);
  localparam int CW = ADDR_WIDTH + 1;

  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("RD_LATENCY must be at least 1");
  end

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_acc, accept;
  logic [DATA_WIDTH-1:0] pat_word;

  ram_fill_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_gen (
    .mode (mode_q),
    .addr (cnt_q[ADDR_WIDTH-1:0]),
    .word (pat_word)
  );

`ifdef RAM_FILL_WRITER_VERIFY_EN
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] exp_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_d [RD_LATENCY];
  logic [2:0]            err_q, err_d;
  logic                  sat_q, sat_d;
  logic                  pass_q, pass_d;
  logic                  rd_en_c;
  logic [DATA_WIDTH-1:0] rd_word;

  ram_fill_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_gen (
    .mode (mode_q),
    .addr (rd_cnt_q[ADDR_WIDTH-1:0]),
    .word (rd_word)
  );
`endif

  always_comb begin
    start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    accept    = (state_q == FILL) && ((mode_q != MODE_STREAM) || bus.s_valid);
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef RAM_FILL_WRITER_VERIFY_EN
    rd_en_c  = (state_q == VERIFY) && !rd_cnt_q[ADDR_WIDTH];
    rd_cnt_d = rd_en_c ? rd_cnt_q + CW'(1) : rd_cnt_q;
    err_d    = err_q;
    sat_d    = sat_q;
    pass_d   = pass_q;
    vld_d[0] = rd_en_c;
    exp_d[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end
    // Stream words are not retained, so there is nothing to compare against in stream mode.
    if (vld_q[RD_LATENCY-1] && (mode_q != MODE_STREAM) && (rd_data != exp_q[RD_LATENCY-1])) begin
      if (!sat_q) begin
        if (err_q == 3'd6) begin
          err_d = 3'd4;
          sat_d = 1'b1;
        end else begin
          err_d = err_q + 3'd1;
        end
      end
    end
    if ((state_q == VERIFY) && rd_cnt_q[ADDR_WIDTH] && (vld_q == '0)) state_d = DONE;
    if (start_acc) begin
      err_d  = '0;
      sat_d  = 1'b0;
      pass_d = 1'b0;
    end else if (state_q == DONE) begin
      pass_d = (err_q == 3'd0);
    end
`endif
    if (start_acc) begin
      state_d = FILL;
      mode_d  = (mode == 2'd3) ? MODE_ONES : mode;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
    if (accept) begin
      wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = (mode_q == MODE_STREAM) ? bus.s_data : pat_word;
      cnt_d     = cnt_q + CW'(1);
      if (cnt_d[ADDR_WIDTH]) begin
`ifdef RAM_FILL_WRITER_VERIFY_EN
        state_d  = VERIFY;
        rd_cnt_d = '0;
`else
        state_d = DONE;
`endif
      end
    end
    // done/busy trail the DONE state by one cycle, so they flip after the final wr_en pulse.
    if ((state_q == DONE) && !start_acc) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_STREAM;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef RAM_FILL_WRITER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      vld_q    <= '0;
      err_q    <= '0;
      sat_q    <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
      pass_q   <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LATENCY; i++) exp_q[i] <= exp_d[i];
  end

  assign rd_en   = rd_en_c;
  assign rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
  assign err_cnt = err_q;
  assign pass    = pass_q;
`endif

  assign bus.s_ready = (state_q == FILL) && (mode_q == MODE_STREAM);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_fill_writer.sv
// Self-checking bench for ram_fill_writer (ADDR_WIDTH=4), built with or without RAM_FILL_WRITER_VERIFY_EN.
// Expected values come from cycle-level rules: write index k-2 on cycle k after start, done after the last write.
module tb_ram_fill_writer;
  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int RDL   = 2;
  localparam int DEPTH = 2**AW;
`ifdef RAM_FILL_WRITER_VERIFY_EN
  localparam int DONE_K = DEPTH + 2 + DEPTH + RDL + 1;
`else
  localparam int DONE_K = DEPTH + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy, done;
  int         n_checks = 0;
  int         n_fail = 0;

  ram_fill_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RAM_FILL_WRITER_VERIFY_EN
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [2:0]    err_cnt;
  logic          pass;
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] corrupt [DEPTH];
  logic [DW-1:0] rd_pipe [RDL];

  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    if (rd_en) rd_pipe[0] <= mem[rd_addr] ^ corrupt[rd_addr];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RDL-1];
`endif

  ram_fill_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
`ifdef RAM_FILL_WRITER_VERIFY_EN
    ,
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .err_cnt (err_cnt),
    .pass    (pass)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_word(input logic [1:0] m, input int a);
    if (m == 2'd2) return DW'(a);
    return {DW{1'b1}};
  endfunction

  // Start a pattern fill and check every output on every cycle against the timing rules.
  task automatic run_fill(input logic [1:0] m, input int mid_k, input string tag);
    logic    want_wr;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    for (int k = 1; k <= DONE_K + 3; k++) begin
      @(negedge clk);
      start   = (k == mid_k);
      mode    = ~m;
      want_wr = (k >= 2) && (k <= DEPTH + 1);
      n_checks++;
      if (bus.wr_en !== want_wr) begin
        n_fail++;
        $display("FAIL %s wr_en k=%0d got=%b want=%b", tag, k, bus.wr_en, want_wr);
      end
      if (want_wr) begin
        n_checks++;
        if ({bus.wr_addr, bus.wr_data} !== {AW'(k - 2), exp_word(m, k - 2)}) begin
          n_fail++;
          $display("FAIL %s write k=%0d got=%0h/%0h want=%0h/%0h", tag, k, bus.wr_addr, bus.wr_data,
                   k - 2, exp_word(m, k - 2));
        end
      end
      n_checks++;
      if (busy !== (k < DONE_K)) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got=%b want=%b", tag, k, busy, (k < DONE_K));
      end
      n_checks++;
      if (done !== (k >= DONE_K)) begin
        n_fail++;
        $display("FAIL %s done k=%0d got=%b want=%b", tag, k, done, (k >= DONE_K));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.s_ready, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs got=%b/%0h/%0h/%b/%b/%b want all zero", bus.wr_en, bus.wr_addr,
               bus.wr_data, bus.s_ready, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.wr_en, bus.s_ready, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle after reset got=%b%b%b%b want=0000", bus.wr_en, bus.s_ready, busy, done);
    end
  endtask

  task automatic test_fill_ones();
    run_fill(2'd1, 0, "ones");
    run_fill(2'd3, 0, "reserved_mode");
  endtask

  task automatic test_fill_addr();
    run_fill(2'd2, 0, "addr_pattern");
  endtask

  task automatic test_stream();
    int            acc = 0;
    int            pend_addr = 0;
    int            post;
    logic          pend = 1'b0;
    logic          fin = 1'b0;
    logic [DW-1:0] pend_data = '0;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    bus.s_valid = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (bus.s_ready !== (acc < DEPTH)) begin
        n_fail++;
        $display("FAIL stream s_ready k=%0d got=%b want=%b", k, bus.s_ready, (acc < DEPTH));
      end
      n_checks++;
      if (bus.wr_en !== pend) begin
        n_fail++;
        $display("FAIL stream wr_en k=%0d got=%b want=%b", k, bus.wr_en, pend);
      end
      if (pend) begin
        n_checks++;
        if ({bus.wr_addr, bus.wr_data} !== {AW'(pend_addr), pend_data}) begin
          n_fail++;
          $display("FAIL stream write k=%0d got=%0h/%0h want=%0h/%0h", k, bus.wr_addr, bus.wr_data,
                   pend_addr, pend_data);
        end
        if (acc == DEPTH) fin = 1'b1;
      end
      pend = 1'b0;
      bus.s_valid = (acc == DEPTH) ? 1'b1 : ((k <= 8) ? k[0] : ($urandom_range(0, 2) != 0));
      bus.s_data  = {$urandom(), $urandom()};
      if (bus.s_valid && (acc < DEPTH)) begin
        pend      = 1'b1;
        pend_addr = acc;
        pend_data = bus.s_data;
        acc++;
      end
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL stream timeout accepted=%0d want=%0d", acc, DEPTH);
    end
    // s_valid stays high here: nothing past the last address may be taken.
    post = DONE_K - DEPTH - 1;
    for (int j = 1; j <= post; j++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.wr_en, bus.s_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL stream overrun j=%0d wr_en=%b s_ready=%b want=0/0", j, bus.wr_en, bus.s_ready);
      end
      n_checks++;
      if (done !== (j == post)) begin
        n_fail++;
        $display("FAIL stream done j=%0d got=%b want=%b", j, done, (j == post));
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stream busy at done got=%b want=0", busy);
    end
`ifdef RAM_FILL_WRITER_VERIFY_EN
    n_checks++;
    if ({err_cnt, pass} !== 4'b0001) begin
      n_fail++;
      $display("FAIL stream verify got err=%0d pass=%b want err=0 pass=1", err_cnt, pass);
    end
`endif
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.wr_en && (bus.wr_addr == AW'(7))) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid never reached addr 7 got=0 want=1");
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({bus.wr_en, bus.wr_addr, bus.s_ready, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid abort got wr_en=%b addr=%0h s_ready=%b busy=%b done=%b want zeros",
               bus.wr_en, bus.wr_addr, bus.s_ready, busy, done);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({bus.wr_en, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid idle got=%b%b%b want=000", bus.wr_en, busy, done);
      end
    end
    run_fill(2'd1, 0, "refill_after_reset");
  endtask

  task automatic test_start_mid();
    run_fill(2'd2, 7, "start_during_fill");
    run_fill(2'd1, 0, "start_in_done");
  endtask

`ifdef RAM_FILL_WRITER_VERIFY_EN
  task automatic test_verify(input int n_bad, input logic [1:0] m);
    int   off = $urandom_range(0, DEPTH - 1);
    int   want_err = (n_bad >= 7) ? 4 : n_bad;
    logic seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) corrupt[i] = '0;
    if (n_bad == 1) corrupt[3] = DW'(1);
    else for (int i = 0; i < n_bad; i++) corrupt[(2 * i + off) % DEPTH] = DW'(1) << $urandom_range(0, DW - 1);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({err_cnt, pass, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL verify clear on start got err=%0d pass=%b done=%b want 0/0/0", err_cnt, pass, done);
    end
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL verify timeout waiting for done got=0 want=1");
    end
    n_checks++;
    if ({err_cnt, pass} !== {3'(want_err), (want_err == 0)}) begin
      n_fail++;
      $display("FAIL verify n_bad=%0d got err=%0d pass=%b want err=%0d pass=%b", n_bad, err_cnt, pass,
               want_err, (want_err == 0));
    end
    for (int i = 0; i < DEPTH; i++) corrupt[i] = '0;
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
`ifdef RAM_FILL_WRITER_VERIFY_EN
    for (int i = 0; i < DEPTH; i++) corrupt[i] = '0;
`endif
    test_reset();
    test_fill_ones();
    test_fill_addr();
    test_stream();
    test_reset_mid();
    test_start_mid();
`ifdef RAM_FILL_WRITER_VERIFY_EN
    test_verify(1, 2'd1);
    test_verify(8, 2'd2);
    test_verify(0, 2'd2);
    test_verify(6, 2'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
